down_counter12_timer: RTL and testbench

- Loadable 12-bit down-counter with a start/done handshake and a one-shot or auto-reload mode.
- Sits directly upstream of the 12-input switch-level NOR zero detector:
  - cnt[11:0] drives the NOR's a..l inputs, with a=cnt[11] through l=cnt[0].
  - The NOR output w returns as zero_in and marks terminal count.
- The counter does not compare against zero itself. The NOR stage is the only terminal-count detector.

---
 rtl/down_counter12_timer.sv | 84 ++++++++
 tb/tb_down_counter12_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter12_timer.sv
// Loadable 12-bit down-counter with start/done handshake and optional auto-reload.
// Terminal count comes only from the external NOR zero detector on zero_in.
module down_counter12_timer #(
  parameter bit          AUTO_RELOAD = 1'b0,
  parameter int unsigned MIN_CLK_NS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        hold,
  input  logic [11:0] load_val,
  input  logic        zero_in,
  output logic [11:0] cnt,
  output logic        busy,
  output logic        done
);

  // The NOR needs about 7 ns to settle; anything tighter cannot meet setup on zero_in.
  if (MIN_CLK_NS < 8) begin : g_min_clk_check
    $error("MIN_CLK_NS too small for the NOR zero detector settle time");
  end

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = load_val;
          state_d = StCount;
        end
      end
      StCount: begin
        if (abort) begin
          state_d = StIdle;
        end else if (zero_in) begin
          state_d = StDone;
        end else if (!hold) begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (AUTO_RELOAD) begin
          cnt_d   = load_val;
          state_d = StCount;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 12'h000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter12_timer.sv
// Directed bench for down_counter12_timer: one-shot and auto-reload instances,
// each closed through a 5 ns delayed NOR model standing in for the zero detector.
module tb_down_counter12_timer;

  logic        clk;
  logic        rst_n;
  logic        start, abort, hold;
  logic [11:0] load_val;
  logic [11:0] cnt_os, cnt_ar;
  logic        busy_os, busy_ar, done_os, done_ar;
  logic        zero_os, zero_ar;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  assign #5 zero_os = ~|cnt_os;
  assign #5 zero_ar = ~|cnt_ar;

  down_counter12_timer #(.AUTO_RELOAD(1'b0), .MIN_CLK_NS(20)) u_os (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .load_val(load_val), .zero_in(zero_os), .cnt(cnt_os), .busy(busy_os), .done(done_os)
  );

  down_counter12_timer #(.AUTO_RELOAD(1'b1), .MIN_CLK_NS(20)) u_ar (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .load_val(load_val), .zero_in(zero_ar), .cnt(cnt_ar), .busy(busy_ar), .done(done_ar)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts a one-shot count of n, holds for hold_len edges after edge hold_from,
  // and returns the edge index (relative to the start edge) at which done shows.
  task automatic measure(input logic [11:0] n, input int hold_from, input int hold_len,
                         input int budget, output int k_done);
    int  k;
    bit  seen_fff;
    bit  zero_bad;
    load_val = n;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    k_done   = -1;
    seen_fff = 1'b0;
    zero_bad = 1'b0;
    while (k < budget) begin
      if (done_os) begin
        k_done = k;
        break;
      end
      hold = (k >= hold_from) && (k < hold_from + hold_len);
      @(posedge clk);
      k++;
      #7;
      if (zero_os !== (cnt_os == 12'h000)) zero_bad = 1'b1;
      if (cnt_os == 12'hFFF) seen_fff = 1'b1;
      @(negedge clk);
    end
    hold = 1'b0;
    chk("zero_in_tracks_cnt", 32'(zero_bad), 32'd0);
    chk("no_wrap_fff", 32'(seen_fff), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("after_done_done", 32'(done_os), 32'd0);
    chk("after_done_busy", 32'(busy_os), 32'd0);
    chk("after_done_cnt", 32'(cnt_os), 32'd0);
  endtask

  typedef struct {
    logic        start;
    logic        abort;
    logic        hold;
    logic [11:0] load_val;
    logic [11:0] cnt;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int k_done;
    int k;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0}; // cnt=0 in idle: no done
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 12'd5, 12'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd4, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1}; // E0+6
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 12'd3, 12'd3, 1'b1, 1'b0}; // start beats abort in idle
    vecs[10] = '{1'b1, 1'b0, 1'b0, 12'd9, 12'd2, 1'b1, 1'b0}; // start while busy ignored
    vecs[11] = '{1'b0, 1'b0, 1'b1, 12'd0, 12'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 12'd0, 12'd2, 1'b0, 1'b0}; // abort beats hold
    vecs[13] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1}; // load 0: done at E0+1
    vecs[16] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    hold     = 1'b0;
    load_val = 12'd0;
    #1;
    chk("reset_cnt", 32'(cnt_os), 32'd0);
    chk("reset_busy", 32'(busy_os), 32'd0);
    chk("reset_done", 32'(done_os), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start    = vecs[i].start;
      abort    = vecs[i].abort;
      hold     = vecs[i].hold;
      load_val = vecs[i].load_val;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_os), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy_os), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done_os), 32'(vecs[i].done));
    end
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;

    measure(12'd5, 0, 0, 50, k_done);
    chk("lat_load5", 32'(k_done), 32'd6);
    measure(12'd0, 0, 0, 50, k_done);
    chk("lat_load0", 32'(k_done), 32'd1);
    measure(12'hFFF, 0, 0, 4200, k_done);
    chk("lat_loadfff", 32'(k_done), 32'd4096);
    measure(12'd10, 3, 3, 60, k_done);
    chk("lat_hold3", 32'(k_done), 32'd14);
    measure(12'h801, 0, 0, 2200, k_done);
    chk("lat_801", 32'(k_done), 32'd2050);

    // Abort at cnt=4: back to idle holding 4, never a done.
    load_val = 12'd10;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cnt_os != 12'd4 && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("abort_reach4", 32'(k), 32'd6);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cnt", 32'(cnt_os), 32'd4);
    chk("abort_busy", 32'(busy_os), 32'd0);
    chk("abort_done", 32'(done_os), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", 32'(done_os), 32'd0);

    // Auto-reload: reload happens on the DONE edge, so each period is N+2 edges.
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    load_val = 12'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ar_k0_cnt", 32'(cnt_ar), 32'd3);
    for (int j = 1; j <= 14; j++) begin
      logic [11:0] pat [5];
      pat[0] = 12'd3; pat[1] = 12'd2; pat[2] = 12'd1; pat[3] = 12'd0; pat[4] = 12'd0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ar_k%0d_cnt", j), 32'(cnt_ar), 32'(pat[j % 5]));
      chk($sformatf("ar_k%0d_done", j), 32'(done_ar), 32'((j % 5) == 4));
      chk($sformatf("ar_k%0d_busy", j), 32'(busy_ar), 32'd1);
    end
    abort = 1'b1; // ar instance is in DONE here
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("ar_abort_busy", 32'(busy_ar), 32'd0);
    chk("ar_abort_cnt", 32'(cnt_ar), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ar_abort_no_reload", 32'(busy_ar), 32'd0);
    chk("ar_abort_no_done", 32'(done_ar), 32'd0);

    // Asynchronous reset mid-count at cnt=7.
    load_val = 12'd10;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cnt_os != 12'd7 && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("rst_reach7", 32'(k), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cnt", 32'(cnt_os), 32'd0);
    chk("rst_async_busy", 32'(busy_os), 32'd0);
    chk("rst_async_done", 32'(done_os), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d_done", j), 32'(done_os), 32'd0);
      chk($sformatf("post_rst_idle%0d_busy", j), 32'(busy_os), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
